// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared types and helpers for the write-through cache to L1.5 path.
//   - dcache_out_t / l15_reqtypes_t / l15_rtrntypes_t encodings
//   - l15_req_t: registered request packet (fields sized at the L1.5 defaults)
//   - swendian64, popcnt64, toSize64, first_byte_idx helpers
//   - arb_state_e: request arbiter FSM states
package wt_cache_pkg;

    localparam int L15_PADDR_W = 56;
    localparam int L15_TID_W   = 2;

    typedef enum logic [1:0] {
        DCACHE_STORE_REQ  = 2'd0,
        DCACHE_LOAD_REQ   = 2'd1,
        DCACHE_ATOMIC_REQ = 2'd2,
        DCACHE_INT_REQ    = 2'd3
    } dcache_out_t;

    typedef enum logic [4:0] {
        L15_LOAD_RQ   = 5'b00000,
        L15_STORE_RQ  = 5'b00001,
        L15_ATOMIC_RQ = 5'b00110,
        L15_INT_RQ    = 5'b01001,
        L15_IMISS_RQ  = 5'b10000
    } l15_reqtypes_t;

    typedef enum logic [3:0] {
        L15_LOAD_RET               = 4'b0000,
        L15_IFILL_RET              = 4'b0001,
        L15_EVICT_REQ              = 4'b0011,
        L15_ST_ACK                 = 4'b0100,
        L15_INT_RET                = 4'b0111,
        L15_ERR_RET                = 4'b1100,
        L15_CPX_RESTYPE_ATOMIC_RES = 4'b1110
    } l15_rtrntypes_t;

    typedef struct packed {
        l15_reqtypes_t           rqtype;
        logic [1:0]              size;
        logic [L15_PADDR_W-1:0]  address;
        logic [63:0]             data;
        logic [L15_TID_W-1:0]    threadid;
    } l15_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_SEND  = 2'd1,
        ARB_SPLIT = 2'd2
    } arb_state_e;

    // L1.5 expects big-endian byte order on the data bus.
    function automatic logic [63:0] swendian64(input logic [63:0] val);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = val[(7-i)*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [6:0] popcnt64(input logic [63:0] val);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(val[i]);
        end
        return cnt;
    endfunction

    // Only naturally aligned byte-enable patterns map to sizes above a byte.
    function automatic logic [1:0] toSize64(input logic [7:0] be);
        logic [1:0] size;
        case (be)
            8'b1111_1111:                     size = 2'b11;
            8'b0000_1111, 8'b1111_0000:       size = 2'b10;
            8'b1100_0000, 8'b0011_0000,
            8'b0000_1100, 8'b0000_0011:       size = 2'b01;
            default:                          size = 2'b00;
        endcase
        return size;
    endfunction

    function automatic logic [2:0] first_byte_idx(input logic [7:0] be);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (be[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wt_l15_req_arbiter_if.sv
// wt_l15_req_arbiter_if: L1.5 request channel.
//   master (arbiter): drives l15_val_o and the packet fields, samples l15_ack_i.
//   slave  (L1.5 adapter): samples the packet, drives l15_ack_i.
interface wt_l15_req_arbiter_if #(
    parameter int PADDR_W = 56,
    parameter int TID_W   = 2
);
    logic               l15_val_o;
    logic               l15_ack_i;
    logic [4:0]         l15_rqtype_o;
    logic [1:0]         l15_size_o;
    logic [PADDR_W-1:0] l15_address_o;
    logic [63:0]        l15_data_o;
    logic [TID_W-1:0]   l15_threadid_o;

    modport master (
        output l15_val_o, l15_rqtype_o, l15_size_o, l15_address_o,
               l15_data_o, l15_threadid_o,
        input  l15_ack_i
    );

    modport slave (
        input  l15_val_o, l15_rqtype_o, l15_size_o, l15_address_o,
               l15_data_o, l15_threadid_o,
        output l15_ack_i
    );
endinterface

// File: rtl/wt_l15_credit_cnt.sv
// wt_l15_credit_cnt: outstanding-transaction counter for one requester.
//   i_inc        one transaction issued (L1.5 ack)
//   i_dec        one transaction returned
//   o_cnt        in-flight count, saturates at MAX_OUT and at 0
//   o_underflow  return seen while nothing was in flight (combinational pulse)
module wt_l15_credit_cnt #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;

    assign o_cnt       = r_cnt;
    assign o_underflow = i_dec && !i_inc && (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != CNT_W'(MAX_OUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/wt_l15_req_arbiter.sv
// wt_l15_req_arbiter: round-robin share of the L1.5 request port between the
// icache (fill misses) and dcache (store/load/atomic/interrupt).
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   ic_req_*                            icache request (valid/ready/paddr)
//   dc_req_*                            dcache request (type/paddr/data/be/tid)
//   l15 (wt_l15_req_arbiter_if.master)  registered request toward L1.5
//   rtrn_val_i, rtrn_type_i             L1.5 return packet type
//   ic/dc_outstanding_o                 in-flight counts per requester
//   err_o                               sticky protocol error
// Build option: WT_ARB_STORE_SPLIT_EN splits sub-dword multi-byte stores into
// byte stores; without it such a store goes out as its lowest byte and flags err_o.
//
// state     | meaning
// ARB_IDLE  | waiting for an eligible requester; grant happens here
// ARB_SEND  | packet presented, waiting for l15_ack_i
// ARB_SPLIT | presenting the next byte of a split store
module wt_l15_req_arbiter
    import wt_cache_pkg::*;
#(
    parameter int PADDR_W = 56,
    parameter int TID_W   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           ic_req_valid_i,
    output logic                           ic_req_ready_o,
    input  logic [PADDR_W-1:0]             ic_req_paddr_i,
    input  logic                           dc_req_valid_i,
    output logic                           dc_req_ready_o,
    input  dcache_out_t                    dc_req_type_i,
    input  logic [PADDR_W-1:0]             dc_req_paddr_i,
    input  logic [63:0]                    dc_req_data_i,
    input  logic [7:0]                     dc_req_be_i,
    input  logic [TID_W-1:0]               dc_req_tid_i,
    wt_l15_req_arbiter_if.master           l15,
    input  logic                           rtrn_val_i,
    input  l15_rtrntypes_t                 rtrn_type_i,
    output logic [$clog2(MAX_OUT+1)-1:0]   ic_outstanding_o,
    output logic [$clog2(MAX_OUT+1)-1:0]   dc_outstanding_o,
    output logic                           err_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    arb_state_e r_state;
    l15_req_t   r_pkt;
    logic       r_val;
    logic       r_rr_dc;     // 1: dcache wins a tie
    logic       r_owner_dc;
    logic       r_is_int;
    logic [7:0] r_mask;      // bytes still to send, current one included
    logic       r_err;
    logic       r_armed;     // keeps ready low until the first clock after reset

    logic [CNT_W-1:0] w_ic_cnt, w_dc_cnt;
    logic             w_ic_uflow, w_dc_uflow;
    logic             w_ic_inc, w_dc_inc, w_ic_dec, w_dc_dec;
    logic             w_ic_elig, w_dc_elig, w_idle;
    logic             w_grant_ic, w_grant_dc;
    logic             w_ack_ok, w_ack_bad, w_split_err;
    logic [1:0]       w_dc_size;
    logic [6:0]       w_dc_pop;
    logic             w_dc_multi;
    logic [7:0]       w_dc_split_mask, w_mask_next;
    l15_req_t         w_ic_pkt, w_dc_pkt;

    assign w_dc_size  = toSize64(dc_req_be_i);
    assign w_dc_pop   = popcnt64({56'd0, dc_req_be_i});
    assign w_dc_multi = (dc_req_type_i == DCACHE_STORE_REQ) && (w_dc_size == 2'b00)
                        && (w_dc_pop > 7'd1);

    assign w_ic_elig = ic_req_valid_i && (w_ic_cnt < CNT_W'(MAX_OUT));

`ifdef WT_ARB_STORE_SPLIT_EN
    // A split store needs credit for every byte up front.
    assign w_dc_elig = dc_req_valid_i &&
                       (w_dc_multi ? ((int'(w_dc_cnt) + int'(w_dc_pop)) <= MAX_OUT)
                                   : (w_dc_cnt < CNT_W'(MAX_OUT)));
    assign w_dc_split_mask = w_dc_multi ? dc_req_be_i : 8'h00;
    assign w_split_err     = 1'b0;
`else
    assign w_dc_elig       = dc_req_valid_i && (w_dc_cnt < CNT_W'(MAX_OUT));
    assign w_dc_split_mask = 8'h00;
    assign w_split_err     = w_grant_dc && w_dc_multi;
`endif

    assign w_idle     = (r_state == ARB_IDLE) && r_armed;
    assign w_grant_ic = w_idle && w_ic_elig && (!w_dc_elig || !r_rr_dc);
    assign w_grant_dc = w_idle && w_dc_elig && (!w_ic_elig || r_rr_dc);

    // Ready is the grant itself so the requester sees acceptance in the
    // cycle its payload is captured.
    assign ic_req_ready_o = w_grant_ic;
    assign dc_req_ready_o = w_grant_dc;

    assign w_ack_ok  = l15.l15_ack_i && (r_state != ARB_IDLE);
    assign w_ack_bad = l15.l15_ack_i && (r_state == ARB_IDLE);
    assign w_ic_inc  = w_ack_ok && !r_owner_dc;
    assign w_dc_inc  = w_ack_ok && r_owner_dc && !r_is_int;
    assign w_ic_dec  = rtrn_val_i && (rtrn_type_i == L15_IFILL_RET);
    assign w_dc_dec  = rtrn_val_i && ((rtrn_type_i == L15_LOAD_RET) ||
                                      (rtrn_type_i == L15_ST_ACK) ||
                                      (rtrn_type_i == L15_CPX_RESTYPE_ATOMIC_RES) ||
                                      (rtrn_type_i == L15_INT_RET));

    // Clearing the lowest set bit; an empty mask stays empty.
    assign w_mask_next = r_mask & (r_mask - 8'd1);

    always_comb begin
        w_ic_pkt         = '0;
        w_ic_pkt.rqtype  = L15_IMISS_RQ;
        w_ic_pkt.size    = 2'b11;
        w_ic_pkt.address = L15_PADDR_W'(ic_req_paddr_i);
    end

    always_comb begin
        w_dc_pkt          = '0;
        w_dc_pkt.address  = L15_PADDR_W'(dc_req_paddr_i);
        w_dc_pkt.data     = swendian64(dc_req_data_i);
        w_dc_pkt.threadid = L15_TID_W'(dc_req_tid_i);
        case (dc_req_type_i)
            DCACHE_STORE_REQ: begin
                w_dc_pkt.rqtype = L15_STORE_RQ;
                w_dc_pkt.size   = w_dc_size;
            end
            DCACHE_LOAD_REQ: begin
                w_dc_pkt.rqtype = L15_LOAD_RQ;
                w_dc_pkt.size   = 2'b11;
            end
            DCACHE_ATOMIC_REQ: begin
                w_dc_pkt.rqtype = L15_ATOMIC_RQ;
                w_dc_pkt.size   = w_dc_size;
            end
            default: begin
                w_dc_pkt.rqtype = L15_INT_RQ;
                w_dc_pkt.size   = 2'b00;
            end
        endcase
        if (w_dc_multi) begin
            w_dc_pkt.address[2:0] = first_byte_idx(dc_req_be_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_pkt      <= '0;
            r_val      <= 1'b0;
            r_rr_dc    <= 1'b0;
            r_owner_dc <= 1'b0;
            r_is_int   <= 1'b0;
            r_mask     <= 8'h00;
            r_err      <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_ic_uflow || w_dc_uflow || w_ack_bad || w_split_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_ic) begin
                        r_pkt      <= w_ic_pkt;
                        r_owner_dc <= 1'b0;
                        r_is_int   <= 1'b0;
                        r_mask     <= 8'h00;
                        r_rr_dc    <= 1'b1;
                        r_val      <= 1'b1;
                        r_state    <= ARB_SEND;
                    end else if (w_grant_dc) begin
                        r_pkt      <= w_dc_pkt;
                        r_owner_dc <= 1'b1;
                        r_is_int   <= (dc_req_type_i == DCACHE_INT_REQ);
                        r_mask     <= w_dc_split_mask;
                        r_rr_dc    <= 1'b0;
                        r_val      <= 1'b1;
                        r_state    <= ARB_SEND;
                    end
                end
                ARB_SEND, ARB_SPLIT: begin
                    if (l15.l15_ack_i) begin
                        r_mask <= w_mask_next;
                        if (w_mask_next != 8'h00) begin
                            r_pkt.address[2:0] <= first_byte_idx(w_mask_next);
                            r_state            <= ARB_SPLIT;
                        end else begin
                            r_val   <= 1'b0;
                            r_state <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    r_val   <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    wt_l15_credit_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_ic_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_inc       (w_ic_inc),
        .i_dec       (w_ic_dec),
        .o_cnt       (w_ic_cnt),
        .o_underflow (w_ic_uflow)
    );

    wt_l15_credit_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_dc_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_inc       (w_dc_inc),
        .i_dec       (w_dc_dec),
        .o_cnt       (w_dc_cnt),
        .o_underflow (w_dc_uflow)
    );

    assign l15.l15_val_o      = r_val;
    assign l15.l15_rqtype_o   = r_pkt.rqtype;
    assign l15.l15_size_o     = r_pkt.size;
    assign l15.l15_address_o  = PADDR_W'(r_pkt.address);
    assign l15.l15_data_o     = r_pkt.data;
    assign l15.l15_threadid_o = TID_W'(r_pkt.threadid);

    assign ic_outstanding_o = w_ic_cnt;
    assign dc_outstanding_o = w_dc_cnt;
    assign err_o            = r_err;

endmodule

// File: tb/tb_wt_l15_req_arbiter.sv
module tb_wt_l15_req_arbiter;
    import wt_cache_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           ic_req_valid;
    logic           ic_req_ready;
    logic [55:0]    ic_req_paddr;
    logic           dc_req_valid;
    logic           dc_req_ready;
    dcache_out_t    dc_req_type;
    logic [55:0]    dc_req_paddr;
    logic [63:0]    dc_req_data;
    logic [7:0]     dc_req_be;
    logic [1:0]     dc_req_tid;
    logic           rtrn_val;
    l15_rtrntypes_t rtrn_type;
    logic [2:0]     ic_out, dc_out;
    logic           err;

    int n_pass  = 0;
    int n_total = 0;

    wt_l15_req_arbiter_if #(.PADDR_W(56), .TID_W(2)) l15 ();

    wt_l15_req_arbiter #(.PADDR_W(56), .TID_W(2), .MAX_OUT(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ic_req_valid_i   (ic_req_valid),
        .ic_req_ready_o   (ic_req_ready),
        .ic_req_paddr_i   (ic_req_paddr),
        .dc_req_valid_i   (dc_req_valid),
        .dc_req_ready_o   (dc_req_ready),
        .dc_req_type_i    (dc_req_type),
        .dc_req_paddr_i   (dc_req_paddr),
        .dc_req_data_i    (dc_req_data),
        .dc_req_be_i      (dc_req_be),
        .dc_req_tid_i     (dc_req_tid),
        .l15              (l15),
        .rtrn_val_i       (rtrn_val),
        .rtrn_type_i      (rtrn_type),
        .ic_outstanding_o (ic_out),
        .dc_outstanding_o (dc_out),
        .err_o            (err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic ic_txn(input logic with_ret);
        ic_req_valid = 1'b1;
        #1;
        check("ic_grant", ic_req_ready, 1);
        cyc();
        ic_req_valid = 1'b0;
        check("ic_val", l15.l15_val_o, 1);
        check("ic_rqtype", l15.l15_rqtype_o, 5'b10000);
        check("ic_size", l15.l15_size_o, 2'b11);
        l15.l15_ack_i = 1'b1;
        if (with_ret) begin
            rtrn_val  = 1'b1;
            rtrn_type = L15_IFILL_RET;
        end
        cyc();
        l15.l15_ack_i = 1'b0;
        rtrn_val      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grants[16];
        int   ng;
        logic ok;
        logic got;

        rst_ni        = 1'b0;
        ic_req_valid  = 1'b0;
        ic_req_paddr  = 56'h00_0000_0000_1000;
        dc_req_valid  = 1'b0;
        dc_req_type   = DCACHE_LOAD_REQ;
        dc_req_paddr  = 56'h00_0000_0000_2000;
        dc_req_data   = 64'h0;
        dc_req_be     = 8'hFF;
        dc_req_tid    = 2'b01;
        rtrn_val      = 1'b0;
        rtrn_type     = L15_LOAD_RET;
        l15.l15_ack_i = 1'b0;

        #3;
        check("rst_val", l15.l15_val_o, 0);
        check("rst_ic_out", ic_out, 0);
        check("rst_dc_out", dc_out, 0);
        check("rst_err", err, 0);
        check("rst_addr", l15.l15_address_o, 0);

        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // Round robin with both requesters always valid and immediate acks.
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        ng = 0;
        for (int c = 0; c < 24; c++) begin
            l15.l15_ack_i = l15.l15_val_o;
            #1;
            if (ic_req_ready && ng < 16) begin grants[ng] = 0; ng++; end
            if (dc_req_ready && ng < 16) begin grants[ng] = 1; ng++; end
            cyc();
        end
        l15.l15_ack_i = 1'b0;
        #1;
        check("rr_grant_count", ng, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr_order_%0d", i), grants[i], i % 2);
        end
        check("rr_ic_full", ic_out, 4);
        check("rr_dc_full", dc_out, 4);
        check("rr_stalled", {ic_req_ready, dc_req_ready}, 2'b00);

        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        rtrn_val     = 1'b1;
        rtrn_type    = L15_IFILL_RET;
        repeat (4) cyc();
        rtrn_type    = L15_LOAD_RET;
        repeat (4) cyc();
        rtrn_val     = 1'b0;
        check("drain_ic", ic_out, 0);
        check("drain_dc", dc_out, 0);
        check("drain_err", err, 0);

        // Store with be=F0: size and byte swap, then hold without ack.
        dc_req_type  = DCACHE_STORE_REQ;
        dc_req_be    = 8'hF0;
        dc_req_data  = 64'h0011223344556677;
        dc_req_paddr = 56'h00_0000_1234_5678;
        dc_req_tid   = 2'b10;
        dc_req_valid = 1'b1;
        #1;
        check("st_grant", dc_req_ready, 1);
        cyc();
        check("st_val", l15.l15_val_o, 1);
        check("st_rqtype", l15.l15_rqtype_o, 5'b00001);
        check("st_size", l15.l15_size_o, 2'b10);
        check("st_data", l15.l15_data_o, 64'h7766554433221100);
        check("st_addr", l15.l15_address_o, 56'h00_0000_1234_5678);
        check("st_tid", l15.l15_threadid_o, 2'b10);
        for (int c = 0; c < 10; c++) begin
            cyc();
            ok = (l15.l15_val_o === 1'b1) && (l15.l15_rqtype_o === 5'b00001) &&
                 (l15.l15_size_o === 2'b10) && (l15.l15_data_o === 64'h7766554433221100) &&
                 (l15.l15_address_o === 56'h00_0000_1234_5678) &&
                 (l15.l15_threadid_o === 2'b10) && (dc_req_ready === 1'b0);
            check($sformatf("hold_%0d", c), ok, 1);
        end
        dc_req_valid  = 1'b0;
        l15.l15_ack_i = 1'b1;
        cyc();
        l15.l15_ack_i = 1'b0;
        check("st_acked_val", l15.l15_val_o, 0);
        check("st_dc_out", dc_out, 1);

        // Same-cycle ack and IFILL return leave the icache count unchanged.
        ic_txn(1'b0);
        ic_txn(1'b0);
        check("ic_out_2", ic_out, 2);
        ic_txn(1'b1);
        check("ic_out_same_cycle", ic_out, 2);

        // Return type handling and underflow.
        rtrn_val  = 1'b1;
        rtrn_type = L15_EVICT_REQ;
        cyc();
        check("evict_ignored", dc_out, 1);
        rtrn_type = L15_ST_ACK;
        cyc();
        check("st_ack_dec", dc_out, 0);
        check("st_ack_noerr", err, 0);
        cyc();
        rtrn_val = 1'b0;
        check("underflow_cnt", dc_out, 0);
        check("underflow_err", err, 1);

        // Asynchronous reset while a packet is in SEND.
        dc_req_be    = 8'hFF;
        dc_req_valid = 1'b1;
        #1;
        check("rst_send_grant", dc_req_ready, 1);
        cyc();
        dc_req_valid = 1'b0;
        check("rst_send_val", l15.l15_val_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_val", l15.l15_val_o, 0);
        check("async_ic_out", ic_out, 0);
        check("async_dc_out", dc_out, 0);
        check("async_err", err, 0);
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        dc_req_type  = DCACHE_LOAD_REQ;
        #1;
        check("rst_no_ready", {ic_req_ready, dc_req_ready}, 2'b00);
        cyc();
        rst_ni = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (!got) begin
                #1;
                if (ic_req_ready || dc_req_ready) got = 1'b1;
                else cyc();
            end
        end
        check("post_rst_grant_seen", got, 1);
        check("post_rst_ic_first", {ic_req_ready, dc_req_ready}, 2'b10);
        cyc();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        check("post_rst_rqtype", l15.l15_rqtype_o, 5'b10000);
        l15.l15_ack_i = 1'b1;
        cyc();
        l15.l15_ack_i = 1'b0;
        check("post_rst_ic_out", ic_out, 1);
        check("post_rst_err", err, 0);

        // Store with non-contiguous byte enables 1010_0010.
        dc_req_type  = DCACHE_STORE_REQ;
        dc_req_be    = 8'b1010_0010;
        dc_req_data  = 64'h0123456789ABCDEF;
        dc_req_paddr = 56'h00_0000_0000_4440;
        dc_req_valid = 1'b1;
        #1;
        check("split_grant", dc_req_ready, 1);
        cyc();
        dc_req_valid = 1'b0;
        check("split_b0_val", l15.l15_val_o, 1);
        check("split_b0_size", l15.l15_size_o, 2'b00);
        check("split_b0_addr", l15.l15_address_o, 56'h00_0000_0000_4441);
        l15.l15_ack_i = 1'b1;
        cyc();
        l15.l15_ack_i = 1'b0;
`ifdef WT_ARB_STORE_SPLIT_EN
        check("split_b1_val", l15.l15_val_o, 1);
        check("split_b1_size", l15.l15_size_o, 2'b00);
        check("split_b1_addr", l15.l15_address_o, 56'h00_0000_0000_4445);
        l15.l15_ack_i = 1'b1;
        cyc();
        l15.l15_ack_i = 1'b0;
        check("split_b2_val", l15.l15_val_o, 1);
        check("split_b2_addr", l15.l15_address_o, 56'h00_0000_0000_4447);
        l15.l15_ack_i = 1'b1;
        cyc();
        l15.l15_ack_i = 1'b0;
        check("split_done_val", l15.l15_val_o, 0);
        check("split_dc_out", dc_out, 3);
        check("split_no_err", err, 0);
        l15.l15_ack_i = 1'b1;
        cyc();
        l15.l15_ack_i = 1'b0;
        check("stray_ack_err", err, 1);
`else
        check("nosplit_val", l15.l15_val_o, 0);
        check("nosplit_dc_out", dc_out, 1);
        check("nosplit_err", err, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
